// File: rtl/design_params_pkg.sv
// rtl/design_params_pkg.sv - shared bus widths, monitor error indices and FSM states
package design_params_pkg;

    localparam int P_ADDR_WIDTH = 8;
    localparam int P_DATA_WIDTH = 16;

    localparam int MON_N_ERR = 5;

    typedef enum logic [2:0] {
        ERR_TIMEOUT = 3'd0,
        ERR_DROP    = 3'd1,
        ERR_SPUR    = 3'd2,
        ERR_EARLY   = 3'd3,
        ERR_STABLE  = 3'd4
    } mon_err_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        TMO  = 2'd2
    } mon_state_e;

endpackage

// File: rtl/req_gnt_chan_mon.sv
// rtl/req_gnt_chan_mon.sv - single-channel req/gnt checker with sticky flags and stats
module req_gnt_chan_mon
    import design_params_pkg::*;
#(
    parameter int MIN_LAT = 1,
    parameter int MAX_LAT = 4,
    parameter int CNT_W   = 16,
    parameter int LAT_W   = $clog2(MAX_LAT + 2)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clr,
    input  logic                    req,
    input  logic                    gnt,
    input  logic                    write_en,
    input  logic [P_ADDR_WIDTH-1:0] addr,
    input  logic [P_DATA_WIDTH-1:0] wdata,
    output logic [MON_N_ERR-1:0]    err_event,
    output logic [MON_N_ERR-1:0]    err_sticky,
    output logic [MON_N_ERR-1:0]    err_pulse,
    output logic [CNT_W-1:0]        txn_cnt,
    output logic [LAT_W-1:0]        max_lat
);

    localparam logic [LAT_W-1:0] L_MIN = LAT_W'(MIN_LAT);
    localparam logic [LAT_W-1:0] L_MAX = LAT_W'(MAX_LAT);

    mon_state_e              r_state;
    logic [LAT_W-1:0]        r_lat;
    logic [P_ADDR_WIDTH-1:0] r_addr;
    logic [P_DATA_WIDTH-1:0] r_wdata;
    logic                    r_we;
    logic                    r_stable_done;
    logic [MON_N_ERR-1:0]    r_sticky;
    logic [MON_N_ERR-1:0]    r_pulse;
    logic [CNT_W-1:0]        r_txn;
    logic [LAT_W-1:0]        r_max_lat;

    mon_state_e              w_state_nxt;
    logic [MON_N_ERR-1:0]    w_ev;
    logic                    w_capture;
    logic                    w_complete;
    logic                    w_max_upd;
    logic                    w_differ;
    logic [LAT_W-1:0]        w_max_base;

    always_comb begin
        w_state_nxt = r_state;
        w_ev        = '0;
        w_capture   = 1'b0;
        w_complete  = 1'b0;
        w_max_upd   = 1'b0;
        w_differ    = (addr != r_addr) || (wdata != r_wdata) || (write_en != r_we);
        // a clear in the same cycle makes the new latency compete against zero
        w_max_base  = clr ? '0 : r_max_lat;
        case (r_state)
            IDLE: begin
                if (req) begin
                    w_capture = 1'b1;
                    if (gnt) begin
                        w_complete      = 1'b1;
                        w_ev[ERR_EARLY] = (MIN_LAT > 0);
                    end else begin
                        w_state_nxt = WAIT;
                    end
                end else if (gnt) begin
                    w_ev[ERR_SPUR] = 1'b1;
                end
            end
            WAIT: begin
                if (req && w_differ && !r_stable_done)
                    w_ev[ERR_STABLE] = 1'b1;
                if (req && gnt) begin
                    w_complete      = 1'b1;
                    w_ev[ERR_EARLY] = (r_lat < L_MIN);
                    w_max_upd       = (r_lat > w_max_base);
                    w_state_nxt     = IDLE;
                end else if (!req) begin
                    w_ev[ERR_SPUR]  = gnt;
                    w_ev[ERR_DROP]  = !gnt;
                    w_state_nxt     = IDLE;
                end else if (r_lat == L_MAX) begin
                    w_ev[ERR_TIMEOUT] = 1'b1;
                    w_state_nxt       = TMO;
                end
            end
            TMO: begin
                if (req && w_differ && !r_stable_done)
                    w_ev[ERR_STABLE] = 1'b1;
                if (req && gnt) begin
                    w_complete  = 1'b1;
                    w_state_nxt = IDLE;
                end else if (!req) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_lat         <= '0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_we          <= 1'b0;
            r_stable_done <= 1'b0;
            r_sticky      <= '0;
            r_pulse       <= '0;
            r_txn         <= '0;
            r_max_lat     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_capture) begin
                r_addr        <= addr;
                r_wdata       <= wdata;
                r_we          <= write_en;
                r_stable_done <= 1'b0;
                r_lat         <= LAT_W'(1);
            end else if (r_state == WAIT && w_state_nxt == WAIT) begin
                r_lat <= r_lat + LAT_W'(1);
            end
            if (w_ev[ERR_STABLE])
                r_stable_done <= 1'b1;
            r_pulse  <= w_ev;
            r_sticky <= (clr ? '0 : r_sticky) | w_ev;
            if (clr)
                r_txn <= w_complete ? CNT_W'(1) : '0;
            else if (w_complete && r_txn != '1)
                r_txn <= r_txn + CNT_W'(1);
            if (w_max_upd)
                r_max_lat <= r_lat;
            else if (clr)
                r_max_lat <= '0;
        end
    end

    assign err_event  = w_ev;
    assign err_sticky = r_sticky;
    assign err_pulse  = r_pulse;
    assign txn_cnt    = r_txn;
    assign max_lat    = r_max_lat;

endmodule

// File: rtl/req_gnt_protocol_monitor.sv
// rtl/req_gnt_protocol_monitor.sv - multi-channel req/gnt protocol monitor top
module req_gnt_protocol_monitor
    import design_params_pkg::*;
#(
    parameter int N_CH    = 2,
    parameter int MIN_LAT = 1,
    parameter int MAX_LAT = 4,
    parameter int CNT_W   = 16,
    parameter int LAT_W   = $clog2(MAX_LAT + 2)
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [N_CH-1:0]              req,
    input  logic [N_CH-1:0]              gnt,
    input  logic [N_CH-1:0]              write_en,
    input  logic [N_CH*P_ADDR_WIDTH-1:0] addr,
    input  logic [N_CH*P_DATA_WIDTH-1:0] wdata,
    input  logic                         clr,
    output logic [N_CH*MON_N_ERR-1:0]    err_sticky,
    output logic [N_CH*MON_N_ERR-1:0]    err_pulse,
    output logic                         irq,
    output logic [N_CH*CNT_W-1:0]        txn_cnt,
    output logic [CNT_W-1:0]             err_cnt,
    output logic [N_CH*LAT_W-1:0]        max_lat
);

    localparam int N_BITS = N_CH * MON_N_ERR;
    localparam int POP_W  = $clog2(N_BITS + 1);

    logic [N_BITS-1:0] w_ev;
    logic [POP_W-1:0]  w_pop;
    logic [CNT_W:0]    w_sum;
    logic [CNT_W-1:0]  r_err_cnt;
    logic              r_irq;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        req_gnt_chan_mon #(
            .MIN_LAT (MIN_LAT),
            .MAX_LAT (MAX_LAT),
            .CNT_W   (CNT_W),
            .LAT_W   (LAT_W)
        ) u_chan (
            .clk        (clk),
            .reset_n    (reset_n),
            .clr        (clr),
            .req        (req[g]),
            .gnt        (gnt[g]),
            .write_en   (write_en[g]),
            .addr       (addr[g*P_ADDR_WIDTH +: P_ADDR_WIDTH]),
            .wdata      (wdata[g*P_DATA_WIDTH +: P_DATA_WIDTH]),
            .err_event  (w_ev[g*MON_N_ERR +: MON_N_ERR]),
            .err_sticky (err_sticky[g*MON_N_ERR +: MON_N_ERR]),
            .err_pulse  (err_pulse[g*MON_N_ERR +: MON_N_ERR]),
            .txn_cnt    (txn_cnt[g*CNT_W +: CNT_W]),
            .max_lat    (max_lat[g*LAT_W +: LAT_W])
        );
    end

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < N_BITS; i++)
            w_pop = w_pop + POP_W'(w_ev[i]);
        w_sum = {1'b0, (clr ? {CNT_W{1'b0}} : r_err_cnt)} + (CNT_W+1)'(w_pop);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err_cnt <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_err_cnt <= w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
            r_irq     <= (|w_ev) | (!clr && (|err_sticky));
        end
    end

    assign err_cnt = r_err_cnt;
    assign irq     = r_irq;

endmodule

// File: tb/tb_req_gnt_protocol_monitor.sv
// tb/tb_req_gnt_protocol_monitor.sv - directed self-checking bench for req_gnt_protocol_monitor
module tb_req_gnt_protocol_monitor;
    import design_params_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  req, gnt, write_en;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic        clr;
    logic [9:0]  err_sticky, err_pulse;
    logic        irq;
    logic [31:0] txn_cnt;
    logic [15:0] err_cnt;
    logic [5:0]  max_lat;

    int n_checks = 0;
    int n_fail   = 0;

    req_gnt_protocol_monitor #(
        .N_CH (2), .MIN_LAT (1), .MAX_LAT (4), .CNT_W (16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .gnt        (gnt),
        .write_en   (write_en),
        .addr       (addr),
        .wdata      (wdata),
        .clr        (clr),
        .err_sticky (err_sticky),
        .err_pulse  (err_pulse),
        .irq        (irq),
        .txn_cnt    (txn_cnt),
        .err_cnt    (err_cnt),
        .max_lat    (max_lat)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; req = '0; gnt = '0; write_en = '0;
        addr = '0; wdata = '0; clr = 1'b0;
        cyc(); cyc();
        if (err_sticky !== 10'h0) begin $display("FAIL reset_sticky: got %h expected 0", err_sticky); n_fail++; end
        n_checks++;
        if (irq !== 1'b0 || err_cnt !== 16'h0) begin $display("FAIL reset_irq_cnt: got irq=%b cnt=%h expected 0/0", irq, err_cnt); n_fail++; end
        n_checks++;
        if (txn_cnt !== 32'h0 || max_lat !== 6'h0) begin $display("FAIL reset_txn_lat: got %h/%h expected 0/0", txn_cnt, max_lat); n_fail++; end
        n_checks++;
        reset_n = 1'b1;
        cyc();
    endtask

    task automatic test_normal();
        req[0] = 1'b1; addr[7:0] = 8'h11; wdata[15:0] = 16'hBEEF; write_en[0] = 1'b1;
        cyc(); cyc(); cyc();
        gnt[0] = 1'b1;
        cyc();
        if (txn_cnt[15:0] !== 16'd1) begin $display("FAIL normal_txn: got %0d expected 1", txn_cnt[15:0]); n_fail++; end
        n_checks++;
        if (max_lat[2:0] !== 3'd3) begin $display("FAIL normal_maxlat: got %0d expected 3", max_lat[2:0]); n_fail++; end
        n_checks++;
        req[0] = 1'b0; gnt[0] = 1'b0; write_en[0] = 1'b0;
        cyc();
        if (err_sticky !== 10'h0 || irq !== 1'b0) begin $display("FAIL normal_noerr: got %h irq=%b expected 0", err_sticky, irq); n_fail++; end
        n_checks++;
    endtask

    task automatic test_timeout();
        req[1] = 1'b1; addr[15:8] = 8'h40;
        cyc(); cyc(); cyc(); cyc();
        if (err_pulse !== 10'h0) begin $display("FAIL tmo_early_pulse: got %h expected 0", err_pulse); n_fail++; end
        n_checks++;
        cyc();
        if (err_pulse !== 10'h020) begin $display("FAIL tmo_pulse: got %h expected 020", err_pulse); n_fail++; end
        n_checks++;
        if (irq !== 1'b1 || err_cnt !== 16'd1) begin $display("FAIL tmo_irq_cnt: got irq=%b cnt=%0d expected 1/1", irq, err_cnt); n_fail++; end
        n_checks++;
        cyc();
        if (err_pulse !== 10'h0 || err_cnt !== 16'd1) begin $display("FAIL tmo_once: got %h cnt=%0d expected 0/1", err_pulse, err_cnt); n_fail++; end
        n_checks++;
        cyc();
        gnt[1] = 1'b1;
        cyc();
        if (txn_cnt[31:16] !== 16'd1 || max_lat[5:3] !== 3'd0) begin $display("FAIL tmo_late_gnt: got txn=%0d lat=%0d expected 1/0", txn_cnt[31:16], max_lat[5:3]); n_fail++; end
        n_checks++;
        req[1] = 1'b0; gnt[1] = 1'b0;
        cyc();
        if (err_sticky !== 10'h020) begin $display("FAIL tmo_sticky: got %h expected 020", err_sticky); n_fail++; end
        n_checks++;
    endtask

    task automatic test_clr_alone();
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        cyc();
        if (err_sticky !== 10'h0 || irq !== 1'b0 || err_cnt !== 16'h0) begin $display("FAIL clr_flags: got %h irq=%b cnt=%0d expected 0", err_sticky, irq, err_cnt); n_fail++; end
        n_checks++;
        if (txn_cnt !== 32'h0 || max_lat !== 6'h0) begin $display("FAIL clr_stats: got %h/%h expected 0/0", txn_cnt, max_lat); n_fail++; end
        n_checks++;
    endtask

    task automatic test_early_drop();
        req[0] = 1'b1; gnt[0] = 1'b1;
        cyc();
        if (err_pulse !== 10'h008) begin $display("FAIL early_pulse: got %h expected 008", err_pulse); n_fail++; end
        n_checks++;
        gnt[0] = 1'b0;
        cyc();
        req[0] = 1'b0;
        cyc();
        if (err_sticky[4:0] !== 5'b01010 || err_cnt !== 16'd2) begin $display("FAIL early_drop: got %b cnt=%0d expected 01010/2", err_sticky[4:0], err_cnt); n_fail++; end
        n_checks++;
        if (txn_cnt[15:0] !== 16'd1) begin $display("FAIL early_txn: got %0d expected 1", txn_cnt[15:0]); n_fail++; end
        n_checks++;
    endtask

    task automatic test_simultaneous();
        req[0] = 1'b1; addr[7:0] = 8'h22;
        cyc();
        addr[7:0] = 8'h23; gnt[1] = 1'b1;
        cyc();
        if (err_pulse !== 10'h090 || err_cnt !== 16'd4) begin $display("FAIL sim_pulse: got %h cnt=%0d expected 090/4", err_pulse, err_cnt); n_fail++; end
        n_checks++;
        gnt[1] = 1'b0; gnt[0] = 1'b1;
        cyc();
        if (err_pulse !== 10'h0 || err_sticky !== 10'h09A) begin $display("FAIL sim_stable_once: got pulse=%h sticky=%h expected 000/09A", err_pulse, err_sticky); n_fail++; end
        n_checks++;
        req[0] = 1'b0; gnt[0] = 1'b0; addr[7:0] = 8'h00;
        cyc();
    endtask

    task automatic test_clr_timeout();
        req[1] = 1'b1;
        cyc(); cyc(); cyc(); cyc();
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        if (err_cnt !== 16'd1 || err_sticky !== 10'h020) begin $display("FAIL clr_set_wins: got cnt=%0d sticky=%h expected 1/020", err_cnt, err_sticky); n_fail++; end
        n_checks++;
        if (txn_cnt !== 32'h0 || max_lat !== 6'h0 || irq !== 1'b1) begin $display("FAIL clr_set_stats: got %h/%h irq=%b expected 0/0/1", txn_cnt, max_lat, irq); n_fail++; end
        n_checks++;
        req[1] = 1'b0;
        cyc();
        if (err_pulse !== 10'h0) begin $display("FAIL tmo_drop_silent: got %h expected 0", err_pulse); n_fail++; end
        n_checks++;
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        if (err_sticky !== 10'h0 || irq !== 1'b0 || err_cnt !== 16'h0) begin $display("FAIL clr_all: got %h irq=%b cnt=%0d expected 0", err_sticky, irq, err_cnt); n_fail++; end
        n_checks++;
    endtask

    task automatic test_back_to_back();
        req[0] = 1'b1;
        cyc(); cyc(); cyc(); cyc();
        gnt[0] = 1'b1;
        cyc();
        if (err_pulse !== 10'h0 || txn_cnt[15:0] !== 16'd1 || max_lat[2:0] !== 3'd4) begin $display("FAIL maxlat_edge: got pulse=%h txn=%0d lat=%0d expected 0/1/4", err_pulse, txn_cnt[15:0], max_lat[2:0]); n_fail++; end
        n_checks++;
        gnt[0] = 1'b0;
        cyc();
        gnt[0] = 1'b1;
        cyc();
        if (txn_cnt[15:0] !== 16'd2 || max_lat[2:0] !== 3'd4 || err_sticky !== 10'h0) begin $display("FAIL b2b: got txn=%0d lat=%0d sticky=%h expected 2/4/0", txn_cnt[15:0], max_lat[2:0], err_sticky); n_fail++; end
        n_checks++;
        req[0] = 1'b0; gnt[0] = 1'b0;
        cyc();
    endtask

    task automatic test_reset_mid();
        req = 2'b11; gnt[1] = 1'b1;
        cyc();
        req[1] = 1'b0; gnt[1] = 1'b0;
        cyc();
        if (irq !== 1'b1 || txn_cnt[31:16] !== 16'd1) begin $display("FAIL pre_reset: got irq=%b txn=%0d expected 1/1", irq, txn_cnt[31:16]); n_fail++; end
        n_checks++;
        #1 reset_n = 1'b0;
        #1;
        if (err_sticky !== 10'h0 || irq !== 1'b0 || err_cnt !== 16'h0 || txn_cnt !== 32'h0) begin $display("FAIL async_reset: got %h irq=%b cnt=%0d txn=%h expected 0", err_sticky, irq, err_cnt, txn_cnt); n_fail++; end
        n_checks++;
        cyc(); cyc();
        reset_n = 1'b1;
        cyc(); cyc(); cyc(); cyc();
        if (err_pulse !== 10'h0) begin $display("FAIL post_reset_early: got %h expected 0", err_pulse); n_fail++; end
        n_checks++;
        cyc();
        if (err_pulse !== 10'h001 || err_cnt !== 16'd1) begin $display("FAIL post_reset_tmo: got %h cnt=%0d expected 001/1", err_pulse, err_cnt); n_fail++; end
        n_checks++;
        req = '0;
        cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_normal();
        test_timeout();
        test_clr_alone();
        test_early_drop();
        test_simultaneous();
        test_clr_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
